// File: rtl/irq_loopback_ring.sv
// rtl/irq_loopback_ring.sv - ring interconnect for per-CPU interrupt words with sticky all-finished detection
module irq_loopback_ring #(
    parameter int CPU_NB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_irq [CPU_NB],
    output logic [31:0]       o_irq [CPU_NB],
    input  logic [CPU_NB-1:0] i_finish,
    output logic [CPU_NB-1:0] o_irq_new,
    output logic              o_done,
    output logic [31:0]       o_done_cycles
);

    logic [31:0]       irq_nxt [CPU_NB];
    logic [CPU_NB-1:0] fin_sticky;
    logic [31:0]       cycles;

    // Destination d listens to its left neighbour; a finished source leaves the word frozen.
    for (genvar d = 0; d < CPU_NB; d++) begin : g_route
        localparam int SRC = (d + CPU_NB - 1) % CPU_NB;
        assign irq_nxt[d] = i_finish[SRC] ? o_irq[d] : i_irq[SRC];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < CPU_NB; d++) begin
                o_irq[d] <= '0;
            end
            o_irq_new <= '0;
        end else begin
            for (int d = 0; d < CPU_NB; d++) begin
                o_irq[d]     <= irq_nxt[d];
                o_irq_new[d] <= (irq_nxt[d] != o_irq[d]);
            end
        end
    end

    // Done lags the last sticky bit by one edge; the counter stops on the edge done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_sticky <= '0;
            o_done     <= 1'b0;
            cycles     <= '0;
        end else begin
            fin_sticky <= fin_sticky | i_finish;
            if (&fin_sticky) begin
                o_done <= 1'b1;
            end
            if (!o_done && (cycles != 32'hFFFF_FFFF)) begin
                cycles <= cycles + 32'd1;
            end
        end
    end

    assign o_done_cycles = cycles;

endmodule

// File: tb/tb_irq_loopback_ring.sv
// tb/tb_irq_loopback_ring.sv - randomized model-checked bench for irq_loopback_ring (4-CPU and 1-CPU rings)
module tb_irq_loopback_ring;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  irq_in  [N];
    logic [31:0]  irq_out [N];
    logic [N-1:0] fin;
    logic [N-1:0] irq_new;
    logic         done;
    logic [31:0]  done_cycles;

    logic [31:0]  irq1_in  [1];
    logic [31:0]  irq1_out [1];
    logic [0:0]   fin1;
    logic [0:0]   irq1_new;
    logic         done1;
    logic [31:0]  done1_cycles;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    irq_loopback_ring #(.CPU_NB(N)) dut (
        .clk(clk), .rst_n(rst_n), .i_irq(irq_in), .o_irq(irq_out), .i_finish(fin),
        .o_irq_new(irq_new), .o_done(done), .o_done_cycles(done_cycles)
    );

    irq_loopback_ring #(.CPU_NB(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_irq(irq1_in), .o_irq(irq1_out), .i_finish(fin1),
        .o_irq_new(irq1_new), .o_done(done1), .o_done_cycles(done1_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what each ring must hold after every edge, from the routing/finish rules.
    bit [31:0]  m_irq [N];
    bit [N-1:0] m_new;
    bit [N-1:0] m_fin;
    bit         m_done;
    longint     m_cnt;
    bit [31:0]  m1_irq;
    bit         m1_new;
    bit         m1_fin;
    bit         m1_done;
    longint     m1_cnt;
    bit [31:0]  v;
    bit         all_fin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < N; d++) m_irq[d] = 0;
            m_new = 0; m_fin = 0; m_done = 0; m_cnt = 0;
            m1_irq = 0; m1_new = 0; m1_fin = 0; m1_done = 0; m1_cnt = 0;
        end else begin
            all_fin = (m_fin == {N{1'b1}});
            if (!m_done && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_done = m_done || all_fin;
            m_fin = m_fin | fin;
            for (int d = 0; d < N; d++) begin
                int s;
                s = (d + N - 1) % N;
                v = fin[s] ? m_irq[d] : irq_in[s];
                m_new[d] = (v != m_irq[d]);
                m_irq[d] = v;
            end
            if (!m1_done && m1_cnt < 64'hFFFF_FFFF) m1_cnt = m1_cnt + 1;
            m1_done = m1_done || m1_fin;
            m1_fin = m1_fin | fin1[0];
            v = fin1[0] ? m1_irq : irq1_in[0];
            m1_new = (v != m1_irq);
            m1_irq = v;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < N; d++) chk("model_irq", irq_out[d], m_irq[d]);
        chk("model_irq_new", {28'd0, irq_new}, {28'd0, m_new});
        chk("model_done", {31'd0, done}, {31'd0, m_done});
        chk("model_cycles", done_cycles, m_cnt[31:0]);
        chk("model1_irq", irq1_out[0], m1_irq);
        chk("model1_irq_new", {31'd0, irq1_new}, {31'd0, m1_new});
        chk("model1_done", {31'd0, done1}, {31'd0, m1_done});
        chk("model1_cycles", done1_cycles, m1_cnt[31:0]);
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    initial begin
        for (int k = 0; k < N; k++) irq_in[k] = $urandom;
        fin = '1;
        irq1_in[0] = $urandom;
        fin1 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cycles", done_cycles, 32'd0);
        chk("rst_irq_new", {28'd0, irq_new}, 32'd0);
        for (int k = 0; k < N; k++) chk("rst_irq", irq_out[k], 32'd0);
        chk("rst_done1", {31'd0, done1}, 32'd0);

        for (int k = 0; k < N; k++) irq_in[k] = 32'd0;
        fin = '0;
        irq1_in[0] = 32'd0;
        fin1 = 1'b0;
        rst_n = 1'b1;
        cyc = 0;
        tick(); chk("cnt1", done_cycles, 32'd1);
        tick(); chk("cnt2", done_cycles, 32'd2);

        for (int k = 0; k < N; k++) irq_in[k] = 32'h1 << k;
        tick();
        chk("ring_o1", irq_out[1], 32'h1);
        chk("ring_o2", irq_out[2], 32'h2);
        chk("ring_o3", irq_out[3], 32'h4);
        chk("ring_o0", irq_out[0], 32'h8);
        chk("ring_new", {28'd0, irq_new}, 32'hF);
        tick(); chk("ring_new_pulse", {28'd0, irq_new}, 32'h0);

        irq1_in[0] = 32'h5A;
        tick(); chk("single_irq", irq1_out[0], 32'h5A);
        fin1 = 1'b1;
        tick(); chk("single_done_early", {31'd0, done1}, 32'd0);
        fin1 = 1'b0;
        tick(); chk("single_done", {31'd0, done1}, 32'd1);

        fin[2] = 1'b1;
        tick();
        irq_in[2] = 32'hDEAD;
        irq_in[0] = 32'h77;
        tick();
        chk("freeze_o3", irq_out[3], 32'h4);
        chk("freeze_new3", {31'd0, irq_new[3]}, 32'd0);
        chk("track_o1", irq_out[1], 32'h77);
        fin = '0;
        tick(); chk("unfreeze_o3", irq_out[3], 32'hDEAD);
        chk("cyc10", done_cycles, 32'd10);

        fin = 4'b0001; tick();
        fin = 4'b0010; tick();
        fin = 4'b0100; tick();
        fin = 4'b1000; tick();
        chk("done_not_yet", {31'd0, done}, 32'd0);
        fin = '0;
        tick();
        chk("done_rise", {31'd0, done}, 32'd1);
        chk("done_cycles15", done_cycles, 32'd15);
        repeat (3) tick();
        chk("done_sticky", {31'd0, done}, 32'd1);
        chk("done_cycles_hold", done_cycles, 32'd15);

        rst_n = 1'b0;
        #1;
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_cycles", done_cycles, 32'd0);
        for (int k = 0; k < N; k++) chk("midrst_irq", irq_out[k], 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc = 0;
        tick(); chk("restart_cnt", done_cycles, 32'd1);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 2) == 0)
                    irq_in[k] = ($urandom_range(0, 1) == 1) ? $urandom : (32'h1 << k);
            end
            fin = '0;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 29) == 0) fin[k] = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) irq1_in[0] = $urandom;
            fin1 = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/irq_loopback_ring.md
# irq_loopback_ring

Interrupt-word interconnect between `CPU_NB` CPU models (plain `cpu` or `cpu_multisim_server`) and the top-level simulation harness. Each CPU drives a 32-bit interrupt word; the block registers it and delivers it to the next CPU in a ring. It also tracks per-CPU finish flags and raises a sticky all-done indication with a cycle count. Sits directly under `top`, between the CPU array and the clock.

## Interface
- `CPU_NB`, 4, number of CPUs in the ring (legal range 1..64).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_irq`  in  `CPU_NB` x 32 (unpacked array)  interrupt word driven by CPU `k` at `i_irq[k]`.
- `o_irq`  out  `CPU_NB` x 32 (unpacked array)  interrupt word delivered to CPU `k`.
- `i_finish`  in  `CPU_NB` (packed)  bit `k` set when CPU `k` has finished; level, may drop.
- `o_irq_new`  out  `CPU_NB` (packed)  one-cycle pulse: `o_irq[k]` changed this cycle.
- `o_done`  out  1  sticky: all CPUs finished.
- `o_done_cycles`  out  32  cycles from reset release to `o_done` rising.

## Operation
- Routing: destination `d` is fed by source `s = (d + CPU_NB - 1) % CPU_NB`. With `CPU_NB == 1`, CPU 0 loops to itself.
- Per destination `d`, the next value is:
  - `i_irq[s]` when `i_finish[s] == 0`.
  - The current `o_irq[d]` (held) when `i_finish[s] == 1`. A finished source is frozen and cannot change its neighbour's word.
- `o_irq_new[d]` is 1 in the cycle after an edge where the registered `o_irq[d]` took a value different from its previous value; otherwise 0.
- Finish tracking:
  - `fin_sticky[k]` sets on any cycle where `i_finish[k] == 1`.
  - `fin_sticky[k]` clears only on reset. A finish flag that drops later does not undo completion.
- Done:
  - `o_done` sets on the edge after `&fin_sticky` first becomes 1 and stays 1 until reset.
  - `o_done` is purely informational; the harness decides whether to call `$finish`.
- Cycle counter:
  - Free-running 32-bit counter, cleared by reset, increments every edge while `o_done == 0`.
  - Saturates at `32'hFFFF_FFFF`; no wrap.
  - `o_done_cycles` shows the live counter until done, then holds its frozen value.
- CPU ring contract, stated for the CPU models and not enforced by this block: CPU `k` writes its index-tagged token `32'h1 << k` on `o_irq`. It asserts `o_finish` after it has observed its left neighbour's token on `i_irq`.

## Timing
- Reset values, all asynchronous:
  - `o_irq[*] = 0`, `o_irq_new = 0`, `o_done = 0`, `o_done_cycles = 0`, `fin_sticky = 0`.
- Latency:
  - `i_irq[s]` to `o_irq[d]`: 1 cycle.
  - `o_irq[d]` change to `o_irq_new[d]` pulse: same cycle (compare against a shadow register), i.e. 1 cycle after the input change.
  - Last `i_finish` bit asserting to `o_done`: 1 cycle if the `fin_sticky` update and the AND share the edge. The implementation uses 2 cycles: sticky register, then done register. This is fixed.
- Simultaneous events:
  - `i_finish[s]` rising in the same cycle that `i_irq[s]` changes: the change is dropped (freeze wins).
  - Other destinations are unaffected.
- Reset mid-operation clears all state immediately. After release, the counter restarts from 0 on the first rising edge.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `rst_n = 0` with `i_irq` = random and `i_finish = 4'hF` -> all outputs 0. Release -> `o_done_cycles` increments 1, 2, 3, ...
- Ring delivery, `CPU_NB = 4`:
  - Drive `i_irq[k] = 32'h1 << k` at cycle 0.
  - At cycle 1: `o_irq = {1:32'h1, 2:32'h2, 3:32'h4, 0:32'h8}`, and `o_irq_new = 4'hF` for exactly one cycle.
- Freeze:
  - Set `i_finish[2] = 1`, then change `i_irq[2]` to `32'hDEAD`.
  - Require `o_irq[3]` unchanged and `o_irq_new[3] = 0`.
  - Require `o_irq[1]` still tracks `i_irq[0]`.
- Done and sticky:
  - Pulse `i_finish` bits 0,1,2,3 one per cycle, each for one cycle, starting at cycle 10.
  - Require `o_done` rising at cycle 15 and `o_done_cycles == 15` held thereafter.
  - `o_done` stays 1 with `i_finish = 0`.
- Reset mid-run: assert `rst_n` low after `o_done` -> `o_done = 0` and `o_irq = 0` immediately, and the counter restarts from 0.
- Single CPU (`CPU_NB = 1`): `i_irq[0] = 32'h5A` -> `o_irq[0] = 32'h5A` after 1 cycle. `i_finish = 1` -> `o_done` after 2 cycles.
